// File: rtl/synth_pkg.sv
// rtl/synth_pkg.sv - shared constants and tag type for the synth multiplier arbiter
package synth_pkg;

    localparam int NUM_MULT_REQ   = 4;
    localparam int MULT16_LATENCY = 2;
    localparam int MULT_ID_W      = $clog2(NUM_MULT_REQ);

    typedef struct packed {
        logic                 valid;
        logic [MULT_ID_W-1:0] id;
        logic                 bypass;
        logic [15:0]          dataa;
    } mult_tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with one-hot grant and rotating pointer
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] gnt
);

    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0] upper, pick, gnt_raw;
    logic [ID_W-1:0]    gnt_idx;

    always_comb begin
        // Requests at or above the pointer take priority; otherwise wrap to the lowest.
        upper   = req & ({NUM_REQ{1'b1}} << rr_ptr_q);
        pick    = (|upper) ? upper : req;
        gnt_raw = pick & (~pick + NUM_REQ'(1));
        gnt     = advance ? gnt_raw : '0;

        gnt_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                gnt_idx = ID_W'(i);
            end
        end

        rr_ptr_d = rr_ptr_q;
        if (|gnt) begin
            rr_ptr_d = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/mult16_arbiter.sv
// rtl/mult16_arbiter.sv - shares one pipelined 16x16 multiplier between synth requesters
module mult16_arbiter
    import synth_pkg::*;
#(
    parameter  int NUM_REQ      = NUM_MULT_REQ,
    parameter  int MULT_LATENCY = MULT16_LATENCY,
    localparam int ID_W         = $clog2(NUM_REQ)
) (
    input  logic                    Clk,
    input  logic                    Reset_n,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [NUM_REQ-1:0]      req_bypass,
    input  logic [NUM_REQ-1:0][15:0] req_dataa,
    input  logic [NUM_REQ-1:0][15:0] req_datab,
    output logic [NUM_REQ-1:0]      gnt,
    output logic [15:0]             mult_dataa,
    output logic [15:0]             mult_datab,
    input  logic [31:0]             mult_result,
    output logic                    result_valid,
    output logic [ID_W-1:0]         result_id,
    output logic [31:0]             result
);

    logic [ID_W-1:0] sel_id;
    logic [15:0]     sel_a, sel_b;
    logic            sel_byp;

    mult_tag_t tag_q [MULT_LATENCY];
    mult_tag_t tag_d [MULT_LATENCY];
    mult_tag_t tag_last;

    logic            result_valid_q, result_valid_d;
    logic [ID_W-1:0] result_id_q, result_id_d;
    logic [31:0]     result_q, result_d;

    // Holding advance low during reset keeps gnt at zero without a separate gate.
    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
        .clk     (Clk),
        .rst_n   (Reset_n),
        .req     (req),
        .advance (Reset_n),
        .gnt     (gnt)
    );

    always_comb begin
        sel_id  = '0;
        sel_a   = '0;
        sel_b   = '0;
        sel_byp = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel_id  = ID_W'(i);
                sel_a   = req_dataa[i];
                sel_b   = req_datab[i];
                sel_byp = req_bypass[i];
            end
        end
        // Bypassed and idle slots present zero so the multiplier inputs stay quiet.
        mult_dataa = sel_byp ? '0 : sel_a;
        mult_datab = sel_byp ? '0 : sel_b;
    end

    always_comb begin
        tag_d[0].valid  = |gnt;
        tag_d[0].id     = MULT_ID_W'(sel_id);
        tag_d[0].bypass = sel_byp;
        tag_d[0].dataa  = sel_a;
        for (int i = 1; i < MULT_LATENCY; i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    assign tag_last = tag_q[MULT_LATENCY-1];

    always_comb begin
        result_valid_d = tag_last.valid;
        result_id_d    = result_id_q;
        result_d       = result_q;
        if (tag_last.valid) begin
            result_id_d = ID_W'(tag_last.id);
            result_d    = tag_last.bypass ? {16'b0, tag_last.dataa} : mult_result;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < MULT_LATENCY; i++) begin
                tag_q[i] <= '0;
            end
            result_valid_q <= 1'b0;
            result_id_q    <= '0;
            result_q       <= '0;
        end else begin
            for (int i = 0; i < MULT_LATENCY; i++) begin
                tag_q[i] <= tag_d[i];
            end
            result_valid_q <= result_valid_d;
            result_id_q    <= result_id_d;
            result_q       <= result_d;
        end
    end

    assign result_valid = result_valid_q;
    assign result_id    = result_id_q;
    assign result       = result_q;

endmodule

// File: tb/tb_mult16_arbiter.sv
// tb/tb_mult16_arbiter.sv - randomized scoreboard bench for mult16_arbiter
module tb_mult16_arbiter;

    localparam int NR  = 4;
    localparam int LAT = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NR-1:0]    req, req_bypass, gnt;
    logic [NR-1:0][15:0] req_dataa, req_datab;
    logic [15:0]      mult_dataa, mult_datab;
    logic [31:0]      mult_result;
    logic             result_valid;
    logic [1:0]       result_id;
    logic [31:0]      result;

    typedef struct {
        int          id;
        logic [31:0] val;
        int          due;
    } exp_t;

    exp_t sbq[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   cyc     = 0;
    int   m_ptr   = 0;
    logic [31:0] p1, p2;

    always #5 clk = ~clk;

    mult16_arbiter #(.NUM_REQ(NR), .MULT_LATENCY(LAT)) dut (
        .Clk          (clk),
        .Reset_n      (rst_n),
        .req          (req),
        .req_bypass   (req_bypass),
        .req_dataa    (req_dataa),
        .req_datab    (req_datab),
        .gnt          (gnt),
        .mult_dataa   (mult_dataa),
        .mult_datab   (mult_datab),
        .mult_result  (mult_result),
        .result_valid (result_valid),
        .result_id    (result_id),
        .result       (result)
    );

    // mult16_ip stand-in: LAT-deep registered multiply
    always @(posedge clk) begin
        p1 <= 32'(mult_dataa) * 32'(mult_datab);
        p2 <= p1;
    end
    assign mult_result = p2;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    endtask

    function automatic int model_pick(input logic [NR-1:0] r, input int p);
        for (int i = 0; i < NR; i++) begin
            int idx;
            idx = (p + i) % NR;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (result_valid) begin
            if (sbq.size() == 0) begin
                chk("spurious_result_valid", 32'd1, 32'd0);
            end else begin
                e = sbq.pop_front();
                chk("result_id", 32'(result_id), e.id);
                chk("result", result, e.val);
                chk("latency", cyc, e.due);
            end
        end else if (sbq.size() > 0 && cyc > sbq[0].due) begin
            void'(sbq.pop_front());
            chk("missing_result", 32'd0, 32'd1);
        end
    end

    task automatic set_req(input int i, input bit byp, input logic [15:0] a, input logic [15:0] b);
        req[i]        = 1'b1;
        req_bypass[i] = byp;
        req_dataa[i]  = a;
        req_datab[i]  = b;
    endtask

    // Called at a negedge with inputs set; returns at the following negedge.
    task automatic step(input bit drop);
        int          k;
        logic [15:0] ea, eb;
        logic [31:0] ev;
        exp_t        e;
        #1;
        k = rst_n ? model_pick(req, m_ptr) : -1;
        chk("gnt", 32'(gnt), (k < 0) ? 32'd0 : (32'd1 << k));
        ea = (k >= 0 && !req_bypass[k]) ? req_dataa[k] : 16'd0;
        eb = (k >= 0 && !req_bypass[k]) ? req_datab[k] : 16'd0;
        chk("mult_dataa", 32'(mult_dataa), 32'(ea));
        chk("mult_datab", 32'(mult_datab), 32'(eb));
        if (k >= 0) begin
            ev    = req_bypass[k] ? {16'h0, req_dataa[k]} : 32'(req_dataa[k]) * 32'(req_datab[k]);
            e.id  = k;
            e.val = ev;
            e.due = cyc + LAT + 1;
            sbq.push_back(e);
            m_ptr = (k + 1) % NR;
        end
        @(negedge clk);
        if (drop && k >= 0) req[k] = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sbq.size() > 0; i++) step(1'b1);
        chk("drain_empty", 32'(sbq.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n      = 1'b0;
        req        = '0;
        req_bypass = '0;
        req_dataa  = '0;
        req_datab  = '0;
        for (int i = 0; i < NR; i++) set_req(i, 1'b0, 16'($urandom), 16'($urandom));
        repeat (2) @(negedge clk);
        #1;
        chk("reset_gnt", 32'(gnt), 32'd0);
        chk("reset_result_valid", 32'(result_valid), 32'd0);
        chk("reset_mult_dataa", 32'(mult_dataa), 32'd0);
        chk("reset_result_id", 32'(result_id), 32'd0);
        chk("reset_result", result, 32'd0);

        // Release with all four requesting: 1,2,4,8,1,2,4,8 back to back.
        @(negedge clk);
        rst_n = 1'b1;
        m_ptr = 0;
        for (int i = 0; i < 8; i++) step(1'b0);
        req = '0;
        drain();

        set_req(2, 1'b0, 16'd300, 16'd7);
        step(1'b1);
        drain();

        set_req(1, 1'b1, 16'hABCD, 16'h5555);
        step(1'b1);
        drain();

        set_req(0, 1'b0, 16'hFFFF, 16'hFFFF);
        step(1'b1);
        set_req(3, 1'b0, 16'h0000, 16'h1234);
        step(1'b1);
        drain();

        // Reset with two tags in flight; both must vanish and the pointer restart.
        set_req(0, 1'b0, 16'h1111, 16'h0003);
        set_req(1, 1'b0, 16'h2222, 16'h0005);
        step(1'b1);
        step(1'b1);
        rst_n = 1'b0;
        sbq.delete();
        m_ptr = 0;
        #1;
        chk("midreset_result_valid", 32'(result_valid), 32'd0);
        chk("midreset_gnt", 32'(gnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        set_req(1, 1'b0, 16'h0042, 16'h0010);
        set_req(3, 1'b0, 16'h0007, 16'h0009);
        step(1'b1);
        req = '0;
        for (int i = 0; i < 6; i++) step(1'b1);
        chk("midreset_drain", 32'(sbq.size()), 32'd0);

        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < NR; i++) begin
                if (!req[i] && $urandom_range(1, 0) == 1) begin
                    logic [15:0] a, b;
                    a = ($urandom_range(7, 0) == 0) ? 16'hFFFF : 16'($urandom);
                    b = ($urandom_range(7, 0) == 0) ? 16'hFFFF : 16'($urandom);
                    set_req(i, $urandom_range(3, 0) == 0, a, b);
                end else if (req[i] && $urandom_range(15, 0) == 0) begin
                    req[i] = 1'b0;
                end
            end
            step(1'b1);
        end
        req = '0;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
